// File: rtl/regfile_read_port_pkg.sv
// Shared sizes, register word type and stage-1 control payload for the register-file read port.
package regfile_read_port_pkg;

  localparam int unsigned NREGS    = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned GRP_N    = 8;
  localparam int unsigned NGRP     = NREGS / GRP_N;
  localparam int unsigned SEL_LO_W = 3;
  localparam int unsigned SEL_HI_W = ADDR_W - SEL_LO_W;

  typedef logic [DATA_W-1:0] word_t;

  typedef struct packed {
    logic [SEL_HI_W-1:0] hi;
    logic                byp;
    word_t               byp_data;
  } s1_ctl_t;

endpackage

// File: rtl/regfile_read_port_if.sv
// Read request / read response handshake bundle of the register-file read port.
interface regfile_read_port_if;
  import regfile_read_port_pkg::*;

  logic              in_valid;
  logic [ADDR_W-1:0] in_sel;
  logic              in_ready;
  logic              out_valid;
  word_t             out_data;
  logic              out_ready;

  modport master (
    output in_valid, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/mux8_1.sv
// Combinational 8:1 word selector used for the stage-1 partial reads.
module mux8_1
  import regfile_read_port_pkg::*;
(
  input  word_t               d [GRP_N],
  input  logic [SEL_LO_W-1:0] sel,
  output word_t               y
);

  assign y = d[sel];

endmodule

// File: rtl/regfile_read_port.sv
// Two-stage pipelined register-file read port with write bypass and hard-wired zero register.
module regfile_read_port
  import regfile_read_port_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  word_t             regs [NREGS],
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  word_t             wr_data,
  regfile_read_port_if.slave bus
);

  logic    s1_v;
  logic    s2_v;
  logic    s2_adv_c;
  logic    s1_adv_c;
  logic    in_ready_c;
  logic    accept_c;
  logic    byp_c;
  word_t   grp_c  [NGRP][GRP_N];
  word_t   part_c [NGRP];
  word_t   s1_part [NGRP];
  s1_ctl_t s1_ctl;
  word_t   out_q;

  // Split the file into groups of eight; register 0 always reads as zero.
  always_comb begin
    for (int g = 0; g < int'(NGRP); g++) begin
      for (int i = 0; i < int'(GRP_N); i++) begin
        grp_c[g][i] = regs[g*int'(GRP_N) + i];
      end
    end
    grp_c[0][0] = '0;
  end

  for (genvar g = 0; g < int'(NGRP); g++) begin : g_mux
    mux8_1 u_mux (
      .d   (grp_c[g]),
      .sel (bus.in_sel[SEL_LO_W-1:0]),
      .y   (part_c[g])
    );
  end

  // A same-cycle write to the requested register wins over the stale file contents.
  assign byp_c = wr_en && (wr_addr == bus.in_sel) && (bus.in_sel != '0);

  assign s2_adv_c   = !s2_v || bus.out_ready;
  assign s1_adv_c   = s1_v && s2_adv_c;
  assign in_ready_c = !s1_v || s1_adv_c;
  assign accept_c   = bus.in_valid && in_ready_c;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = s2_v;
  assign bus.out_data  = out_q;

  // Stage 1: capture the partial reads and bypass decision; bubbles leave data untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v   <= 1'b0;
      s1_ctl <= '0;
      for (int g = 0; g < int'(NGRP); g++) begin
        s1_part[g] <= '0;
      end
    end else begin
      if (in_ready_c) begin
        s1_v <= accept_c;
      end
      if (accept_c) begin
        s1_part <= part_c;
        s1_ctl  <= '{hi: bus.in_sel[ADDR_W-1:SEL_LO_W], byp: byp_c, byp_data: wr_data};
      end
    end
  end

  // Stage 2: final group select; holds while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_v  <= 1'b0;
      out_q <= '0;
    end else if (s2_adv_c) begin
      s2_v <= s1_v;
      if (s1_v) begin
        out_q <= s1_ctl.byp ? s1_ctl.byp_data : s1_part[s1_ctl.hi];
      end
    end
  end

endmodule

// File: tb/tb_regfile_read_port.sv
// Directed bench for regfile_read_port with an in-order expected-result queue.
module tb_regfile_read_port;
  import regfile_read_port_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n;
  word_t             regs [NREGS];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  word_t             wr_data;

  regfile_read_port_if bus ();

  regfile_read_port dut (
    .clk     (clk),
    .reset_n (reset_n),
    .regs    (regs),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  word_t exp_q [$];
  word_t got [$];
  int    got_cyc [$];
  int    acc_cyc [$];
  int    cyc_n = 0;
  logic  stall_prev = 1'b0;
  word_t hold_data = '0;
  int    ng;
  int    na;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // What a read of sel must return, judged in its acceptance cycle.
  function automatic word_t model(input logic [ADDR_W-1:0] sel);
    if (sel == '0) return '0;
    if (wr_en && wr_addr == sel) return wr_data;
    return regs[sel];
  endfunction

  // Compare process: every handshake on either side is resolved at the following rising edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", {31'b0, bus.out_valid}, 32'd1);
        check("hold_data", bus.out_data, hold_data);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", bus.out_data, 32'hxxxx_xxxx);
        end else begin
          check("out_data", bus.out_data, exp_q.pop_front());
        end
        got.push_back(bus.out_data);
        got_cyc.push_back(cyc_n);
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      hold_data  = bus.out_data;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.in_sel));
        acc_cyc.push_back(cyc_n);
      end
      cyc_n++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic send(input logic [ADDR_W-1:0] sel);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!bus.in_ready) check("send_timeout", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n       = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sel    = '0;
    bus.out_ready = 1'b1;
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    for (int k = 0; k < int'(NREGS); k++) regs[k] = 32'hA000_0000 + 32'(k);
    #1 reset_n = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out_data", bus.out_data, 32'h0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Sweep every register back-to-back.
    na = acc_cyc.size();
    ng = got.size();
    for (int k = 0; k < int'(NREGS); k++) send(ADDR_W'(k));
    idle(4);
    check("sweep_count", 32'(got.size() - ng), 32'd32);
    if (got.size() >= ng + 32) begin
      check("sweep_r0", got[ng], 32'h0);
      check("sweep_r1", got[ng+1], 32'hA000_0001);
      check("sweep_r31", got[ng+31], 32'hA000_001F);
      check("sweep_latency", 32'(got_cyc[ng] - acc_cyc[na]), 32'd2);
      check("sweep_throughput", 32'(got_cyc[ng+31] - got_cyc[ng]), 32'd31);
    end

    // Write bypass, register 0, and a write to a different register.
    ng = got.size();
    regs[5] = 32'h1111_1111;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    send(5'd5);
    regs[5] = 32'hDEAD_BEEF;
    regs[0] = 32'h1234_5678;
    wr_addr = 5'd0; wr_data = 32'hCAFE_F00D;
    send(5'd0);
    regs[6] = 32'h6666_6666;
    wr_addr = 5'd9; wr_data = 32'h0000_0001;
    send(5'd6);
    regs[9] = 32'h0000_0001;
    wr_en = 1'b0;
    idle(4);
    check("byp_count", 32'(got.size() - ng), 32'd3);
    if (got.size() >= ng + 3) begin
      check("byp_hit", got[ng], 32'hDEAD_BEEF);
      check("byp_r0", got[ng+1], 32'h0);
      check("byp_miss", got[ng+2], 32'h6666_6666);
    end

    // Later write must not disturb an in-flight read.
    ng = got.size();
    regs[7] = 32'h7;
    send(5'd7);
    regs[7] = 32'h77;
    idle(4);
    check("inflight_count", 32'(got.size() - ng), 32'd1);
    if (got.size() >= ng + 1) check("inflight_data", got[ng], 32'h7);

    // Backpressure: fill the pipe, then release it while a request waits.
    ng = got.size();
    bus.out_ready = 1'b0;
    send(5'd1);
    send(5'd2);
    bus.in_valid = 1'b1;
    bus.in_sel   = 5'd3;
    @(negedge clk);
    check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
    check("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
    check("bp_out_data", bus.out_data, 32'hA000_0001);
    repeat (3) @(negedge clk);
    check("bp_in_ready_held", {31'b0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    #1 check("bp_release_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    idle(5);
    check("bp_count", 32'(got.size() - ng), 32'd3);
    if (got.size() >= ng + 3) begin
      check("bp_first", got[ng], 32'hA000_0001);
      check("bp_second", got[ng+1], 32'hA000_0002);
      check("bp_third", got[ng+2], 32'hA000_0003);
      check("bp_gap1", 32'(got_cyc[ng+1] - got_cyc[ng]), 32'd1);
      check("bp_gap2", 32'(got_cyc[ng+2] - got_cyc[ng+1]), 32'd1);
    end

    // Reset mid-cycle with both stages full.
    bus.out_ready = 1'b0;
    send(5'd10);
    send(5'd11);
    @(posedge clk);
    #3;
    check("prerst_out_valid", {31'b0, bus.out_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("midrst_out_data", bus.out_data, 32'h0);
    check("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #2;
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    regs[31]      = 32'hFFFF_0000;
    na = acc_cyc.size();
    ng = got.size();
    send(5'd31);
    idle(4);
    check("postrst_count", 32'(got.size() - ng), 32'd1);
    if (got.size() >= ng + 1 && acc_cyc.size() >= na + 1) begin
      check("postrst_data", got[ng], 32'hFFFF_0000);
      check("postrst_latency", 32'(got_cyc[ng] - acc_cyc[na]), 32'd2);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_read_port.md
REGFILE_READ_PORT -- requirements
Module: regfile_read_port

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all other ports SHALL be synchronous to clk.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 regs  input  32x32  unpacked array of register-file contents, index = register number.
REQ-005 wr_en  input  1  register-file write strobe, same cycle as the write-side demux.
REQ-006 wr_addr  input  5  register being written.
REQ-007 wr_data  input  32  data being written.
REQ-008 in_valid  input  1  read request present.
REQ-009 in_sel  input  5  register number to read.
REQ-010 in_ready  output  1  request accepted when in_valid and in_ready are both high.
REQ-011 out_valid  output  1  out_data holds a completed read.
REQ-012 out_data  output  32  read result.
REQ-013 out_ready  input  1  consumer takes out_data when out_valid and out_ready are both high.

Function
REQ-014 Two-stage pipeline: S1 captures four 8:1 partial results selected by in_sel[2:0], plus in_sel[4:3], a bypass flag and bypass data; S2 picks one partial by sel[4:3] and registers out_data.
REQ-015 Latency SHALL be exactly 2 cycles from acceptance to out_valid when out_ready stays high; throughput SHALL be 1 read per cycle.
REQ-016 Read value SHALL be the register contents in the acceptance cycle; later writes to the same register SHALL NOT change an in-flight result.
REQ-017 Bypass: if wr_en=1, wr_addr=in_sel and in_sel!=0 in the acceptance cycle, the result SHALL be wr_data, not regs[in_sel].
REQ-018 Register 0: in_sel=0 SHALL return 32'h0 regardless of regs[0] and of any write to address 0.
REQ-019 Stage valid bits s1_v and s2_v: S2 advances when !s2_v or out_ready; S1 advances into S2 when s1_v and S2 advances; in_ready = !s1_v or S1 advances.
REQ-020 out_valid = s2_v; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 Full pipeline with out_ready=0: in_ready SHALL be 0; no request SHALL be dropped or duplicated.
REQ-022 If out_ready rises while both stages are full, S2 and S1 SHALL shift and a new request SHALL be accepted in the same cycle.
REQ-023 in_valid=1 with in_ready=0 SHALL have no effect; the requester holds in_sel.
REQ-024 Bubbles (in_valid=0) SHALL propagate as s1_v=0 and SHALL NOT modify the data registers.

Reset
REQ-025 Asserting reset_n low SHALL immediately clear s1_v, s2_v, out_valid, out_data and all S1 data and flag registers to 0.
REQ-026 During reset, in_ready SHALL be 1; the first request SHALL be accepted on the first rising edge after reset_n deasserts.
REQ-027 Reset during an in-flight read SHALL discard that read with no output.

Structure
REQ-028 A shared package SHALL hold NREGS=32, DATA_W=32, ADDR_W=5 and the typedef for a 32-bit register word.
REQ-029 One sub-module, mux8_1 (combinational, 8 words in, 3-bit select), SHALL be instantiated four times in S1; S2 selection and the bypass logic SHALL be inline.

Verification
REQ-030 regs[k]=32'hA000_0000+k; issue in_sel 0..31 back-to-back with out_ready=1 -> outputs 0, A000_0001..A000_001F, one per cycle, first output 2 cycles after the first acceptance.
REQ-031 regs[5]=32'h1111_1111; in_sel=5 with wr_en=1, wr_addr=5, wr_data=32'hDEAD_BEEF in the same cycle -> out_data=DEAD_BEEF; the same request with wr_addr=0 and in_sel=0 -> 0.
REQ-032 Accept in_sel=7 (regs[7]=32'h7); next cycle change regs[7] to 32'h77 -> out_data=32'h7.
REQ-033 out_ready=0 while issuing in_sel=1,2,3 continuously -> in_ready falls after 2 acceptances and out_data holds regs[1]; out_ready=1 -> outputs regs[1], regs[2], regs[3] in order with no gaps or duplicates.
REQ-034 Drive reset_n low mid-cycle with s1_v=s2_v=1 -> out_valid=0 and out_data=0 immediately, with no clock edge needed; after release, in_sel=31 (regs[31]=32'hFFFF_0000) -> FFFF_0000 after 2 cycles.
